// File: rtl/pp_pkg.sv
// Shared types and defaults for the post-processing line sequencer.
package pp_pkg;

    localparam int AWIDTH_DEF = 11;
    localparam int TWIDTH_DEF = 8;
    localparam int DISP_W_DEF = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BLANK  = 3'd1,
        ACTIVE = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } pp_state_e;

endpackage

// File: rtl/pp_down_timer.sv
// Loadable down-counter used for both per-line blanking and flush.
// Loaded with (cycles-1); zero_o marks the final cycle of the interval.
module pp_down_timer #(
    parameter int TWIDTH = pp_pkg::TWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [TWIDTH-1:0] load_val_i,
    output logic              zero_o
);

    logic [TWIDTH-1:0] cnt_q, cnt_d;

    // Load wins; otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - TWIDTH'(1);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pp_line_sequencer.sv
// Frame/line sequencer ahead of the stereo post-processing pipeline.
// Gates the upstream disparity stream line by line with optional blanking
// before and flush (drain) cycles after each line.
// Optional output-beat checker: define PP_OUTCHK_EN.
module pp_line_sequencer
    import pp_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int TWIDTH = TWIDTH_DEF,
    parameter int DISP_W = DISP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] cfg_width,
    input  logic [AWIDTH-1:0] cfg_height,
    input  logic [TWIDTH-1:0] cfg_blank,
    input  logic [TWIDTH-1:0] cfg_flush,
    input  logic [DISP_W-1:0] cfg_range,
    input  logic              src_valid,
`ifdef PP_OUTCHK_EN
    input  logic              pp_out_valid,
    input  logic              pp_out_clken,
    output logic              out_mismatch,
`endif
    output logic              src_ready,
    output logic              pp_clken,
    output logic              pp_valid,
    output logic              pp_enable,
    output logic [AWIDTH-1:0] pp_width,
    output logic [DISP_W-1:0] pp_range,
    output logic [AWIDTH-1:0] line_idx,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    pp_state_e         state_q, state_d;
    logic [AWIDTH-1:0] width_q, width_d;
    logic [AWIDTH-1:0] height_q, height_d;
    logic [TWIDTH-1:0] blank_q, blank_d;
    logic [TWIDTH-1:0] flush_q, flush_d;
    logic [DISP_W-1:0] range_q, range_d;
    logic [AWIDTH-1:0] pix_q, pix_d;
    logic [AWIDTH-1:0] line_q, line_d;
    logic              cfg_err_q, cfg_err_d;

    logic              tmr_load;
    logic [TWIDTH-1:0] tmr_val;
    logic              tmr_zero;
    logic              line_end;
    logic              start_ok;

    assign start_ok = (state_q == IDLE) && start &&
                      (cfg_width != '0) && (cfg_height != '0);

    pp_down_timer #(.TWIDTH(TWIDTH)) u_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Next-state, counter and pipeline-gating decode.
    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        height_d  = height_q;
        blank_d   = blank_q;
        flush_d   = flush_q;
        range_d   = range_q;
        pix_d     = pix_q;
        line_d    = line_q;
        cfg_err_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        line_end  = 1'b0;
        src_ready = 1'b0;
        pp_clken  = 1'b0;
        pp_valid  = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((cfg_width == '0) || (cfg_height == '0)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        width_d  = cfg_width;
                        height_d = cfg_height;
                        blank_d  = cfg_blank;
                        flush_d  = cfg_flush;
                        range_d  = cfg_range;
                        pix_d    = '0;
                        line_d   = '0;
                        // Zero blanking goes straight to the first beat.
                        if (cfg_blank != '0) begin
                            state_d  = BLANK;
                            tmr_load = 1'b1;
                            tmr_val  = cfg_blank - TWIDTH'(1);
                        end else begin
                            state_d  = ACTIVE;
                        end
                    end
                end
            end
            BLANK: begin
                if (tmr_zero) state_d = ACTIVE;
            end
            ACTIVE: begin
                src_ready = 1'b1;
                pp_valid  = src_valid;
                pp_clken  = src_valid;
                if (src_valid) begin
                    if (pix_q == width_q - AWIDTH'(1)) begin
                        pix_d = '0;
                        if (flush_q != '0) begin
                            state_d  = FLUSH;
                            tmr_load = 1'b1;
                            tmr_val  = flush_q - TWIDTH'(1);
                        end else begin
                            line_end = 1'b1;
                        end
                    end else begin
                        pix_d = pix_q + AWIDTH'(1);
                    end
                end
            end
            FLUSH: begin
                pp_clken = 1'b1;
                if (tmr_zero) line_end = 1'b1;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Line wrap-up shared by the ACTIVE (no flush) and FLUSH exits.
        if (line_end) begin
            if (line_q == height_q - AWIDTH'(1)) begin
                state_d = DONE;
            end else begin
                line_d = line_q + AWIDTH'(1);
                if (blank_q != '0) begin
                    state_d  = BLANK;
                    tmr_load = 1'b1;
                    tmr_val  = blank_q - TWIDTH'(1);
                end else begin
                    state_d  = ACTIVE;
                end
            end
        end
    end

    // State, latched config and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            width_q   <= '0;
            height_q  <= '0;
            blank_q   <= '0;
            flush_q   <= '0;
            range_q   <= '0;
            pix_q     <= '0;
            line_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            height_q  <= height_d;
            blank_q   <= blank_d;
            flush_q   <= flush_d;
            range_q   <= range_d;
            pix_q     <= pix_d;
            line_q    <= line_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign pp_enable = (state_q != IDLE);
    assign line_idx  = line_q;
    assign pp_width  = width_q;
    assign pp_range  = range_q;
    assign cfg_err   = cfg_err_q;

`ifdef PP_OUTCHK_EN
    logic [2*AWIDTH-1:0] ochk_q, ochk_d;
    logic [2*AWIDTH-1:0] ochk_sum;
    logic [2*AWIDTH-1:0] ochk_exp;

    // A beat landing in the DONE cycle itself still counts toward the frame.
    assign ochk_sum = ochk_q + (2*AWIDTH)'(pp_out_valid && pp_out_clken);
    assign ochk_exp = (2*AWIDTH)'(width_q) * (2*AWIDTH)'(height_q);

    // Output-beat counter, cleared when a frame is accepted.
    always_comb begin
        ochk_d = ochk_sum;
        if (start_ok) ochk_d = '0;
    end

    // Output-beat counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ochk_q <= '0;
        else      ochk_q <= ochk_d;
    end

    assign out_mismatch = done && (ochk_sum != ochk_exp);
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_pp_line_sequencer.sv
// Directed bench for pp_line_sequencer (4x2 frame traces, stalls,
// illegal/ignored starts, zero blank/flush, mid-frame reset).
module tb_pp_line_sequencer;

    localparam int AW = 11;
    localparam int TW = 8;
    localparam int DW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_width = '0;
    logic [AW-1:0] cfg_height = '0;
    logic [TW-1:0] cfg_blank = '0;
    logic [TW-1:0] cfg_flush = '0;
    logic [DW-1:0] cfg_range = '0;
    logic          src_valid = 1'b0;
    logic          src_ready, pp_clken, pp_valid, pp_enable, busy, done, cfg_err;
    logic [AW-1:0] pp_width, line_idx;
    logic [DW-1:0] pp_range;

    int chk_cnt = 0;
    int err_cnt = 0;

`ifdef PP_OUTCHK_EN
    logic       pp_out_valid, pp_out_clken, out_mismatch;
    logic [1:0] dly = '0;
    logic       drop = 1'b0;
    int         drop_c = 0;
    logic       exp_mm = 1'b0;
    always @(posedge clk) dly <= {dly[0], pp_valid & ~drop};
    assign pp_out_valid = dly[1];
    assign pp_out_clken = 1'b1;
`endif

    pp_line_sequencer #(.AWIDTH(AW), .TWIDTH(TW), .DISP_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_blank    (cfg_blank),
        .cfg_flush    (cfg_flush),
        .cfg_range    (cfg_range),
        .src_valid    (src_valid),
`ifdef PP_OUTCHK_EN
        .pp_out_valid (pp_out_valid),
        .pp_out_clken (pp_out_clken),
        .out_mismatch (out_mismatch),
`endif
        .src_ready    (src_ready),
        .pp_clken     (pp_clken),
        .pp_valid     (pp_valid),
        .pp_enable    (pp_enable),
        .pp_width     (pp_width),
        .pp_range     (pp_range),
        .line_idx     (line_idx),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start pulse across one posedge; the next negedge lies in cycle 1.
    task automatic cfg_start(input int w, input int h, input int b, input int f, input int r);
        @(posedge clk); #1;
        cfg_width  = AW'(w);
        cfg_height = AW'(h);
        cfg_blank  = TW'(b);
        cfg_flush  = TW'(f);
        cfg_range  = DW'(r);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    // 4x2, blank 3, flush 2, src_valid=1: active 4-7/13-16, flush 8-9/17-18,
    // done 19. Optionally injects a start (different width) at cycle inj.
    task automatic std_trace(input string tag, input int inj);
        logic ev, ef;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
`ifdef PP_OUTCHK_EN
            drop = (c == drop_c);
`endif
            #1;
            ev = ((c >= 4) && (c <= 7)) || ((c >= 13) && (c <= 16));
            ef = (c == 8) || (c == 9) || (c == 17) || (c == 18);
            chk($sformatf("%s pp_valid c%0d", tag, c), 32'(pp_valid), 32'(ev));
            chk($sformatf("%s pp_clken c%0d", tag, c), 32'(pp_clken), 32'(ev || ef));
            chk($sformatf("%s src_ready c%0d", tag, c), 32'(src_ready), 32'(ev));
            chk($sformatf("%s done c%0d", tag, c), 32'(done), 32'(c == 19));
            chk($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'(c <= 19));
            chk($sformatf("%s pp_enable c%0d", tag, c), 32'(pp_enable), 32'(c <= 19));
            if (c <= 19)
                chk($sformatf("%s line_idx c%0d", tag, c), 32'(line_idx), (c >= 10) ? 32'd1 : 32'd0);
            if (c == 8) begin
                chk($sformatf("%s pp_width", tag), 32'(pp_width), 32'd4);
                chk($sformatf("%s pp_range", tag), 32'(pp_range), 32'd77);
            end
`ifdef PP_OUTCHK_EN
            chk($sformatf("%s out_mismatch c%0d", tag, c), 32'(out_mismatch), 32'((c == 19) && exp_mm));
`endif
            if (inj != 0 && c == inj) begin
                cfg_width = AW'(9);
                start     = 1'b1;
            end else if (inj != 0 && c == inj + 1) begin
                start     = 1'b0;
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ph;
        int   beats0, beats1, gaps, dones, done_c;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst pp_valid", 32'(pp_valid), 0);
        chk("rst pp_clken", 32'(pp_clken), 0);
        chk("rst pp_width", 32'(pp_width), 0);
        chk("rst line_idx", 32'(line_idx), 0);
        chk("rst cfg_err", 32'(cfg_err), 0);
        rst = 1'b1;
        src_valid = 1'b1;

        // basic 4x2 frame
        cfg_start(4, 2, 3, 2, 77);
        std_trace("base", 0);

        // alternate src_valid in ACTIVE: 3 gaps per line, done at 25
        cfg_start(4, 2, 3, 2, 77);
        ph = 1'b1; beats0 = 0; beats1 = 0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (src_ready) begin
                src_valid = ph;
                ph = ~ph;
            end else begin
                src_valid = 1'b1;
                ph = 1'b1;
            end
            #1;
            if (pp_valid && line_idx == 0) beats0++;
            if (pp_valid && line_idx == 1) beats1++;
            if (src_ready)
                chk($sformatf("stall clken c%0d", c), 32'(pp_clken), 32'(src_valid));
            chk($sformatf("stall done c%0d", c), 32'(done), 32'(c == 25));
        end
        src_valid = 1'b1;
        chk("stall beats line0", beats0, 4);
        chk("stall beats line1", beats1, 4);

        // illegal start
        cfg_start(0, 2, 3, 2, 5);
        @(negedge clk);
        chk("w0 cfg_err", 32'(cfg_err), 1);
        chk("w0 busy", 32'(busy), 0);
        @(negedge clk);
        chk("w0 cfg_err clr", 32'(cfg_err), 0);
        chk("w0 busy2", 32'(busy), 0);
        cfg_start(3, 0, 3, 2, 5);
        @(negedge clk);
        chk("h0 cfg_err", 32'(cfg_err), 1);
        chk("h0 busy", 32'(busy), 0);

        // start during ACTIVE ignored
        cfg_start(4, 2, 3, 2, 77);
        std_trace("ign", 5);

        // zero blank/flush, 640 wide: back-to-back lines
        cfg_start(640, 8, 0, 0, 1);
        gaps = 0; dones = 0; beats0 = 0; done_c = 0;
        for (int c = 1; c <= 5123; c++) begin
            @(negedge clk); #1;
            if (pp_valid) beats0++;
            if (c <= 5120 && !pp_valid) gaps++;
            if (done) begin dones++; done_c = c; end
        end
        chk("zb beats", beats0, 5120);
        chk("zb gaps", gaps, 0);
        chk("zb dones", dones, 1);
        chk("zb done cycle", done_c, 5121);
        chk("zb busy end", 32'(busy), 0);

        // reset during line 1 ACTIVE
        cfg_start(4, 2, 3, 2, 77);
        repeat (14) @(negedge clk);
        chk("pre-rst line_idx", 32'(line_idx), 1);
        chk("pre-rst pp_valid", 32'(pp_valid), 1);
        rst = 1'b0;
        #1;
        chk("mid-rst busy", 32'(busy), 0);
        chk("mid-rst pp_valid", 32'(pp_valid), 0);
        chk("mid-rst pp_clken", 32'(pp_clken), 0);
        chk("mid-rst src_ready", 32'(src_ready), 0);
        chk("mid-rst pp_enable", 32'(pp_enable), 0);
        chk("mid-rst line_idx", 32'(line_idx), 0);
        chk("mid-rst pp_width", 32'(pp_width), 0);
        chk("mid-rst pp_range", 32'(pp_range), 0);
        @(negedge clk);
        rst = 1'b1;
        cfg_start(4, 2, 3, 2, 77);
        std_trace("post-rst", 0);

`ifdef PP_OUTCHK_EN
        // one output beat dropped -> mismatch with done
        exp_mm = 1'b1;
        drop_c = 5;
        cfg_start(4, 2, 3, 2, 77);
        std_trace("drop", 0);
        exp_mm = 1'b0;
        drop_c = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
